// File: rtl/run_ctrl.sv
// run_ctrl - run/halt sequencer for the pipelined core.
//
// Starts the pipeline on `start` (one-cycle flush on the first RUN cycle).
// Watches the writeback halt indication and captures the return value.
// After a halt it drains the in-flight stages for DRAIN_CYCLES cycles with
// run low. A watchdog ends the run after MAX_CYCLES RUN cycles. DONE or
// TIMEOUT status is held until the host acknowledges it.
//
// Ports:
//   clk      in   system clock, all state on the rising edge
//   rst_n    in   asynchronous active-low reset
//   start    in   begin execution (sampled in IDLE only)
//   isHalt   in   halt reached writeback (sampled in RUN only)
//   ret_val  in   [31:0] return value, valid with isHalt
//   ack      in   host acknowledge of DONE/TIMEOUT
//   run      out  pipeline advance enable (high iff state==RUN)
//   flush    out  one-cycle flush pulse on the first RUN cycle
//   done     out  normal halt, result valid
//   timeout  out  cycle budget exhausted without halt
//   result   out  [31:0] captured ret_val
//   cycles   out  [CNT_W-1:0] RUN cycles elapsed
//   state    out  [2:0] IDLE=0 RUN=1 DRAIN=2 DONE=3 TIMEOUT=4
//
// Optional macro RUN_CTRL_SIM_REPORT_EN (simulation only):
//   - on entering DONE: prints the captured value as %08h, then calls
//     $finish one cycle later;
//   - on entering TIMEOUT: prints "ran for <MAX_CYCLES> cycles", then
//     calls $finish.
// With the macro undefined the block is fully synthesizable.
module run_ctrl #(
    parameter int unsigned MAX_CYCLES   = 500,
    parameter int unsigned DRAIN_CYCLES = 4,
    parameter int unsigned CNT_W        = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             isHalt,
    input  logic [31:0]      ret_val,
    input  logic             ack,
    output logic             run,
    output logic             flush,
    output logic             done,
    output logic             timeout,
    output logic [31:0]      result,
    output logic [CNT_W-1:0] cycles,
    output logic [2:0]       state
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_RUN     = 3'd1,
        S_DRAIN   = 3'd2,
        S_DONE    = 3'd3,
        S_TIMEOUT = 3'd4
    } state_e;

    // The drain counter holds DRAIN_CYCLES-1 at most.
    localparam int unsigned DW = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
    localparam logic [DW-1:0] DRAIN_INIT =
        (DRAIN_CYCLES > 0) ? DW'(DRAIN_CYCLES - 1) : '0;
    localparam logic [CNT_W-1:0] CYC_LAST = CNT_W'(MAX_CYCLES - 1);
    localparam logic [CNT_W-1:0] CYC_MAX  = CNT_W'(MAX_CYCLES);

    state_e            state_q, state_d;
    logic              run_q, run_d;
    logic              flush_q, flush_d;
    logic              done_q, done_d;
    logic              timeout_q, timeout_d;
    logic [31:0]       result_q, result_d;
    logic [CNT_W-1:0]  cycles_q, cycles_d;
    logic [DW-1:0]     drain_q, drain_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            run_q     <= 1'b0;
            flush_q   <= 1'b0;
            done_q    <= 1'b0;
            timeout_q <= 1'b0;
            result_q  <= '0;
            cycles_q  <= '0;
            drain_q   <= '0;
        end else begin
            state_q   <= state_d;
            run_q     <= run_d;
            flush_q   <= flush_d;
            done_q    <= done_d;
            timeout_q <= timeout_d;
            result_q  <= result_d;
            cycles_q  <= cycles_d;
            drain_q   <= drain_d;
        end
    end

    // Flag outputs are recomputed every cycle from the next state, so each
    // branch only raises the flags that belong to the state it lands in.
    always_comb begin
        state_d   = state_q;
        run_d     = 1'b0;
        flush_d   = 1'b0;
        done_d    = 1'b0;
        timeout_d = 1'b0;
        result_d  = result_q;
        cycles_d  = cycles_q;
        drain_d   = drain_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d  = S_RUN;
                    cycles_d = '0;
                    result_d = '0;
                    run_d    = 1'b1;
                    flush_d  = 1'b1;
                end
            end

            S_RUN: begin
                // Halt wins over the watchdog on the same edge.
                if (isHalt) begin
                    result_d = ret_val;
                    cycles_d = cycles_q + CNT_W'(1);
                    if (DRAIN_CYCLES > 0) begin
                        state_d = S_DRAIN;
                        drain_d = DRAIN_INIT;
                    end else begin
                        state_d = S_DONE;
                        done_d  = 1'b1;
                    end
                end else if (cycles_q == CYC_LAST) begin
                    state_d   = S_TIMEOUT;
                    cycles_d  = CYC_MAX;
                    timeout_d = 1'b1;
                end else begin
                    cycles_d = cycles_q + CNT_W'(1);
                    run_d    = 1'b1;
                end
            end

            S_DRAIN: begin
                if (drain_q == '0) begin
                    state_d = S_DONE;
                    done_d  = 1'b1;
                end else begin
                    drain_d = drain_q - DW'(1);
                end
            end

            S_DONE: begin
                if (ack) state_d = S_IDLE;
                else     done_d  = 1'b1;
            end

            S_TIMEOUT: begin
                if (ack) state_d = S_IDLE;
                else     timeout_d = 1'b1;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign run     = run_q;
    assign flush   = flush_q;
    assign done    = done_q;
    assign timeout = timeout_q;
    assign result  = result_q;
    assign cycles  = cycles_q;
    assign state   = state_q;

`ifdef RUN_CTRL_SIM_REPORT_EN
    logic enter_done_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            enter_done_q <= 1'b0;
        end else begin
            enter_done_q <= (state_q != S_DONE) && (state_d == S_DONE);
            if ((state_q != S_DONE) && (state_d == S_DONE))
                $display("%08h", result_d);
            if (enter_done_q)
                $finish;
            if ((state_q != S_TIMEOUT) && (state_d == S_TIMEOUT)) begin
                $display("ran for %0d cycles", MAX_CYCLES);
                $finish;
            end
        end
    end
`endif

endmodule

// File: doc/run_ctrl.md
Name: run_ctrl

Overview:
- Run/halt sequencer for the pipelined core.
- Gates pipeline advance (run) and issues a one-cycle flush at program start.
- Monitors the writeback halt indication and captures the return value; after halt, drains in-flight stages for a fixed count.
- Enforces a cycle-budget watchdog, reports done/timeout, and holds status until the host/bench acknowledges.

Parameters:
MAX_CYCLES, 500, RUN-state cycle budget before timeout (>=1)
DRAIN_CYCLES, 4, post-halt cycles with run=0 before DONE (0 allowed = no drain)
CNT_W, 32, width of cycle counter

Ports:
clk  input  1  system clock, all state on rising edge
rst_n  input  1  asynchronous active-low reset
start  input  1  begin program execution (sampled in IDLE only)
isHalt  input  1  halt instruction reached writeback (sampled in RUN only)
ret_val  input  32  return value register contents, valid with isHalt
ack  input  1  host acknowledge of DONE/TIMEOUT
run  output  1  pipeline advance enable
flush  output  1  one-cycle pipeline flush pulse at program start
done  output  1  program halted normally, result valid
timeout  output  1  cycle budget exhausted without halt
result  output  32  captured ret_val
cycles  output  CNT_W  RUN cycles elapsed
state  output  3  IDLE=0 RUN=1 DRAIN=2 DONE=3 TIMEOUT=4

Behaviour:
- All outputs registered.
- rst_n=0 (async, any state, mid-run included) forces state=IDLE and run=flush=done=timeout=0, result=0, cycles=0, drain counter=0. Deassertion takes effect on the next clk edge.
- IDLE:
  - start=1 -> RUN next cycle.
  - On that edge: cycles<=0, result<=0, run<=1, flush<=1.
  - flush is high for exactly the first RUN cycle, then 0.
- RUN: run=1. Each edge with no exit condition: cycles<=cycles+1.
  - isHalt=1 -> result<=ret_val, run<=0, cycles<=cycles+1. Then:
    - DRAIN_CYCLES>0: state<=DRAIN, drain counter<=DRAIN_CYCLES-1.
    - DRAIN_CYCLES=0: state<=DONE, done<=1.
  - Otherwise, if cycles==MAX_CYCLES-1 -> TIMEOUT, cycles<=MAX_CYCLES, run<=0, timeout<=1.
  - isHalt has priority over timeout on the same edge.
  - Total RUN cycles before timeout = MAX_CYCLES exactly.
- DRAIN: run=0, cycles frozen.
  - Counter decrements each edge.
  - When counter==0: state<=DONE, done<=1.
  - DRAIN lasts DRAIN_CYCLES cycles.
- DONE: done=1, result and cycles held. ack=1 -> IDLE, done<=0.
- TIMEOUT: timeout=1, result=0 held. ack=1 -> IDLE, timeout<=0.
- Ignored inputs:
  - start outside IDLE is ignored, including on the ack edge; a new start must be presented in IDLE.
  - isHalt outside RUN is ignored.
  - ack outside DONE/TIMEOUT is ignored.
- done and timeout are never both 1. run=1 iff state==RUN.
- cycles width: MAX_CYCLES must fit in CNT_W. No wrap is possible because the watchdog stops counting at MAX_CYCLES.
- Illegal state encodings (5-7) return to IDLE on the next edge.

Optional Feature:
- Macro RUN_CTRL_SIM_REPORT_EN.
- When defined (simulation only), on the edge entering DONE:
  - $display the captured ret_val as "%08h".
  - If the macro is defined and ack is never given, the bench still ends: $finish is called one cycle after entering DONE.
- On entering TIMEOUT: $display "ran for <MAX_CYCLES> cycles", then $finish.
- When undefined: no system tasks, fully synthesizable, termination solely via done/timeout/ack.

Test Plan:
- Reset then start: start=1 one cycle -> next cycle state=1, run=1, flush=1, cycles=0; following cycle flush=0, cycles=1.
- Normal halt: isHalt=1 with ret_val=0x0000002A on 10th RUN cycle (cycles=9) -> result=0x2A, run=0, DRAIN for 4 cycles, then done=1, cycles=10; ack -> IDLE, done=0.
- Watchdog: MAX_CYCLES=500, isHalt never asserted -> run high exactly 500 cycles, then timeout=1, cycles=500, result=0; ack -> IDLE.
- Simultaneous: isHalt=1 on the cycle cycles==499 -> DRAIN/DONE path taken, timeout stays 0, result=ret_val.
- DRAIN_CYCLES=0, and isHalt/start while in DONE: DRAIN_CYCLES=0 -> DONE on the edge after halt. In DONE, isHalt/start have no effect; ack+start same cycle -> IDLE, not RUN.
- Async reset mid-DRAIN: rst_n=0 asynchronously -> state=0, all outputs 0 immediately, without waiting for clk.
